// File: rtl/door_lock_pkg.sv
// Shared types and constants for the door-lock keypad front end.
package door_lock_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] KEY_STAR = 4'hA;
  localparam logic [BCD_W-1:0] KEY_HASH = 4'hB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    OPEN    = 3'd3,
    LOCKOUT = 3'd4
  } state_e;

  // True for key codes 0-9.
  function automatic logic is_digit(input logic [BCD_W-1:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/dl_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT windows; stops at zero.
module dl_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_verify.sv
// Keypad entry, code verification, open window and failed-attempt lockout.
module keypad_verify
  import door_lock_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 1000,
  parameter int unsigned LOCK_CYCLES = 5000
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    KEY_VALID,
  input  logic [3:0]              KEY_CODE,
  input  logic [BCD_W*DIGITS-1:0] PW,
  input  logic [BCD_W*DIGITS-1:0] PW_TEMP,
  input  logic                    PW_TEMP_VALID,
  output logic [BCD_W*DIGITS-1:0] DISPLAY,
  output logic                    CORRECT,
  output logic                    PW_TEMP_RESET,
  output logic                    ALARM,
  output logic [1:0]              FAIL_CNT
);

  localparam int unsigned DW   = BCD_W * DIGITS;
  localparam int unsigned CW   = $clog2(DIGITS + 1);
  localparam int unsigned FW   = 2;
  localparam int unsigned MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  state_e        state_q;
  logic [DW-1:0] display_q;
  logic [CW-1:0] count_q;
  logic [FW-1:0] fail_cnt_q;
  logic          submit_full_q;
  logic          correct_q;
  logic          tmp_rst_q;
  logic          alarm_q;

  logic          t_load;
  logic          t_dec;
  logic [TW-1:0] t_val;
  logic          t_zero;

  // Key decode; codes C-F never count as accepted keys.
  logic          key_ok;
  logic          key_dig;
  logic          key_star;
  logic          key_hash;
  logic          full;
  logic [DW-1:0] shifted;
  logic          pw_hit;
  logic          tmp_hit;
  logic          match;
  logic          miss_lock;

  assign key_ok    = KEY_VALID && (KEY_CODE <= KEY_HASH);
  assign key_dig   = KEY_VALID && is_digit(KEY_CODE);
  assign key_star  = KEY_VALID && (KEY_CODE == KEY_STAR);
  assign key_hash  = KEY_VALID && (KEY_CODE == KEY_HASH);
  assign full      = (count_q == CW'(DIGITS));
  assign shifted   = {display_q[DW-BCD_W-1:0], KEY_CODE};
  assign pw_hit    = submit_full_q && (display_q == PW);
  assign tmp_hit   = submit_full_q && PW_TEMP_VALID && (display_q == PW_TEMP);
  assign match     = pw_hit || tmp_hit;
  assign miss_lock = ((fail_cnt_q + FW'(1)) == FW'(MAX_FAIL));

  // Timer control: load on entering OPEN/LOCKOUT or on a key while open.
  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = OPEN_LOAD;
    case (state_q)
      CHECK: begin
        if (match) begin
          t_load = 1'b1;
        end else if (miss_lock) begin
          t_load = 1'b1;
          t_val  = LOCK_LOAD;
        end
      end
      OPEN: begin
        if (key_ok) t_load = 1'b1;
        else        t_dec  = 1'b1;
      end
      LOCKOUT: t_dec = 1'b1;
      default: ;
    endcase
  end

  dl_timer #(.W(TW)) u_timer (
    .clk_i      (CLK),
    .rst_n_i    (RESET_N),
    .load_i     (t_load),
    .dec_i      (t_dec),
    .load_val_i (t_val),
    .zero_o     (t_zero)
  );

  // Main sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      display_q     <= '0;
      count_q       <= '0;
      fail_cnt_q    <= '0;
      submit_full_q <= 1'b0;
      correct_q     <= 1'b0;
      tmp_rst_q     <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      tmp_rst_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_dig) begin
            display_q <= DW'(KEY_CODE);
            count_q   <= CW'(1);
            state_q   <= ENTRY;
          end
        end
        ENTRY: begin
          if (key_dig) begin
            if (!full) begin
              display_q <= shifted;
              count_q   <= count_q + CW'(1);
            end
          end else if (key_star) begin
            display_q <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
          end else if (key_hash) begin
            submit_full_q <= full;
            // Temp-code consume pulse lines up with the CHECK cycle; PW wins a tie.
            tmp_rst_q     <= full && PW_TEMP_VALID && (display_q == PW_TEMP) &&
                             (display_q != PW);
            state_q       <= CHECK;
          end
        end
        CHECK: begin
          display_q <= '0;
          count_q   <= '0;
          if (match) begin
            fail_cnt_q <= '0;
            correct_q  <= 1'b1;
            state_q    <= OPEN;
          end else begin
            fail_cnt_q <= fail_cnt_q + FW'(1);
            if (miss_lock) begin
              alarm_q <= 1'b1;
              state_q <= LOCKOUT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        OPEN: begin
          if (key_dig && !full) begin
            display_q <= shifted;
            count_q   <= count_q + CW'(1);
          end
          if (!key_ok && t_zero) begin
            display_q <= '0;
            count_q   <= '0;
            correct_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        LOCKOUT: begin
          if (t_zero) begin
            fail_cnt_q <= '0;
            alarm_q    <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DISPLAY       = display_q;
  assign CORRECT       = correct_q;
  assign PW_TEMP_RESET = tmp_rst_q;
  assign ALARM         = alarm_q;
  assign FAIL_CNT      = fail_cnt_q;

endmodule

// File: tb/tb_keypad_verify.sv
// Bench for keypad_verify: digit-queue reference model checked every cycle plus directed literals.
module tb_keypad_verify;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned MAX_FAIL    = 3;
  localparam int unsigned OPEN_CYCLES = 16;
  localparam int unsigned LOCK_CYCLES = 40;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_CODE = 4'h0;
  logic [15:0] PW = 16'h1234;
  logic [15:0] PW_TEMP = 16'h0000;
  logic        PW_TEMP_VALID = 1'b0;
  logic [15:0] DISPLAY;
  logic        CORRECT;
  logic        PW_TEMP_RESET;
  logic        ALARM;
  logic [1:0]  FAIL_CNT;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int correct_cyc = 0;
  int alarm_cyc   = 0;
  int pulse_cyc   = 0;

  always #5 CLK = ~CLK;

  keypad_verify #(
    .DIGITS      (DIGITS),
    .MAX_FAIL    (MAX_FAIL),
    .OPEN_CYCLES (OPEN_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .KEY_VALID     (KEY_VALID),
    .KEY_CODE      (KEY_CODE),
    .PW            (PW),
    .PW_TEMP       (PW_TEMP),
    .PW_TEMP_VALID (PW_TEMP_VALID),
    .DISPLAY       (DISPLAY),
    .CORRECT       (CORRECT),
    .PW_TEMP_RESET (PW_TEMP_RESET),
    .ALARM         (ALARM),
    .FAIL_CNT      (FAIL_CNT)
  );

  // Reference model: typed digits in a queue, a phase and a remaining-cycles count.
  localparam int PH_IDLE = 0, PH_TYPING = 1, PH_VERDICT = 2, PH_UNLOCKED = 3, PH_ALARMED = 4;
  int q[$];
  int m_phase = PH_IDLE;
  int m_fail  = 0;
  int m_left  = 0;
  bit m_full  = 1'b0;
  bit m_pulse = 1'b0;

  function automatic logic [15:0] code_of_queue();
    logic [15:0] v;
    v = 16'h0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model on every rising edge from the inputs present at that edge.
  always @(posedge CLK) begin
    int kc;
    bit hit_pw, hit_tmp;
    kc = int'(KEY_CODE);
    m_pulse = 1'b0;
    if (!RESET_N) begin
      q.delete();
      m_phase = PH_IDLE;
      m_fail  = 0;
      m_left  = 0;
      m_full  = 1'b0;
    end else begin
      case (m_phase)
        PH_IDLE: if (KEY_VALID && kc <= 9) begin
          q.delete();
          q.push_back(kc);
          m_phase = PH_TYPING;
        end
        PH_TYPING: if (KEY_VALID) begin
          if (kc <= 9) begin
            if (q.size() < DIGITS) q.push_back(kc);
          end else if (kc == 10) begin
            q.delete();
            m_phase = PH_IDLE;
          end else if (kc == 11) begin
            m_full  = (q.size() == DIGITS);
            m_pulse = m_full && PW_TEMP_VALID && (code_of_queue() == PW_TEMP) &&
                      (code_of_queue() != PW);
            m_phase = PH_VERDICT;
          end
        end
        PH_VERDICT: begin
          hit_pw  = m_full && (code_of_queue() == PW);
          hit_tmp = m_full && PW_TEMP_VALID && (code_of_queue() == PW_TEMP);
          q.delete();
          if (hit_pw || hit_tmp) begin
            m_fail  = 0;
            m_left  = OPEN_CYCLES;
            m_phase = PH_UNLOCKED;
          end else begin
            m_fail = m_fail + 1;
            if (m_fail == MAX_FAIL) begin
              m_left  = LOCK_CYCLES;
              m_phase = PH_ALARMED;
            end else begin
              m_phase = PH_IDLE;
            end
          end
        end
        PH_UNLOCKED: begin
          if (KEY_VALID && kc <= 11) begin
            if (kc <= 9 && q.size() < DIGITS) q.push_back(kc);
            m_left = OPEN_CYCLES;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
              q.delete();
              m_phase = PH_IDLE;
            end
          end
        end
        PH_ALARMED: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_fail  = 0;
            m_phase = PH_IDLE;
          end
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  // Compare DUT against the model away from the active edge, and count output activity.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("m_display", 32'(DISPLAY), 32'(code_of_queue()));
      chk("m_correct", 32'(CORRECT), 32'(m_phase == PH_UNLOCKED));
      chk("m_alarm", 32'(ALARM), 32'(m_phase == PH_ALARMED));
      chk("m_fail_cnt", 32'(FAIL_CNT), 32'(m_fail));
      chk("m_tmp_rst", 32'(PW_TEMP_RESET), 32'(m_pulse));
    end
    if (CORRECT === 1'b1)       correct_cyc++;
    if (ALARM === 1'b1)         alarm_cyc++;
    if (PW_TEMP_RESET === 1'b1) pulse_cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    KEY_VALID = 1'b1;
    KEY_CODE  = c;
    tick();
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'h0;
    tick();
  endtask

  // Strobe HASH and return in the CHECK cycle.
  task automatic submit();
    KEY_VALID = 1'b1;
    KEY_CODE  = 4'hB;
    tick();
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'h0;
  endtask

  task automatic press_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) press(code[4*i +: 4]);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (!CORRECT && !ALARM) done = 1'b1;
      else tick();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: CORRECT=%b ALARM=%b still high after 500 cycles", CORRECT, ALARM);
    end
  endtask

  initial begin
    tick();
    tick();
    cmp_en = 1'b1;
    chk("reset_display", 32'(DISPLAY), 32'h0);
    chk("reset_correct", 32'(CORRECT), 32'h0);
    chk("reset_alarm", 32'(ALARM), 32'h0);
    chk("reset_fail", 32'(FAIL_CNT), 32'h0);
    RESET_N = 1'b1;
    tick();

    // Master code.
    press_code(16'h1234);
    chk("master_entry", 32'(DISPLAY), 32'h1234);
    correct_cyc = 0;
    pulse_cyc   = 0;
    submit();
    chk("master_check_no_correct", 32'(CORRECT), 32'h0);
    tick();
    chk("master_latency", 32'(CORRECT), 32'h1);
    wait_idle();
    chk("master_open_len", 32'(correct_cyc), 32'(OPEN_CYCLES));
    chk("master_no_tmp_rst", 32'(pulse_cyc), 32'h0);
    chk("master_exit_display", 32'(DISPLAY), 32'h0);

    // Temporary code consumed once; digits shift in while open.
    PW_TEMP = 16'h5678;
    PW_TEMP_VALID = 1'b1;
    press_code(16'h5678);
    pulse_cyc = 0;
    submit();
    chk("tmp_rst_in_check", 32'(PW_TEMP_RESET), 32'h1);
    chk("tmp_check_no_correct", 32'(CORRECT), 32'h0);
    tick();
    chk("tmp_rst_dropped", 32'(PW_TEMP_RESET), 32'h0);
    chk("tmp_correct", 32'(CORRECT), 32'h1);
    press(4'h9);
    chk("open_shift", 32'(DISPLAY), 32'h0009);
    wait_idle();
    chk("tmp_rst_once", 32'(pulse_cyc), 32'h1);
    PW_TEMP_VALID = 1'b0;

    // Both codes equal: PW wins, no consume pulse.
    PW_TEMP = 16'h1234;
    PW_TEMP_VALID = 1'b1;
    press_code(16'h1234);
    pulse_cyc = 0;
    submit();
    tick();
    chk("tie_correct", 32'(CORRECT), 32'h1);
    wait_idle();
    chk("tie_no_tmp_rst", 32'(pulse_cyc), 32'h0);
    PW_TEMP_VALID = 1'b0;

    // Clear, ignored code, overflow.
    press(4'h1);
    press(4'h2);
    press(4'hC);
    chk("ignored_code", 32'(DISPLAY), 32'h0012);
    press(4'hA);
    chk("star_clear", 32'(DISPLAY), 32'h0);
    press_code(16'h1234);
    press(4'h5);
    chk("overflow_hold", 32'(DISPLAY), 32'h1234);
    submit();
    tick();
    chk("overflow_correct", 32'(CORRECT), 32'h1);
    wait_idle();

    // Short code is a miss even when the value matches.
    PW = 16'h0123;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    submit();
    tick();
    chk("short_fail_cnt", 32'(FAIL_CNT), 32'h1);
    chk("short_no_correct", 32'(CORRECT), 32'h0);
    PW = 16'h1234;

    // Reset while open.
    press_code(16'h1234);
    submit();
    tick();
    press(4'h7);
    chk("pre_reset_display", 32'(DISPLAY), 32'h0007);
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    chk("rst_open_display", 32'(DISPLAY), 32'h0);
    chk("rst_open_correct", 32'(CORRECT), 32'h0);
    chk("rst_open_fail", 32'(FAIL_CNT), 32'h0);
    chk("rst_open_alarm", 32'(ALARM), 32'h0);
    tick();

    // Lockout after three misses; keys ignored while alarmed.
    for (int k = 1; k <= 3; k++) begin
      press_code(16'h0000);
      alarm_cyc   = 0;
      correct_cyc = 0;
      submit();
      tick();
      if (k < 3) begin
        chk("lock_fail_step", 32'(FAIL_CNT), 32'(k));
      end else begin
        chk("lock_alarm_on", 32'(ALARM), 32'h1);
        chk("lock_fail_full", 32'(FAIL_CNT), 32'h3);
      end
    end
    press_code(16'h1234);
    press(4'hB);
    wait_idle();
    chk("lock_alarm_len", 32'(alarm_cyc), 32'(LOCK_CYCLES));
    chk("lock_no_correct", 32'(correct_cyc), 32'h0);
    chk("lock_fail_clear", 32'(FAIL_CNT), 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
